uart_lsu_bridge: RTL and testbench

UART_LSU_BRIDGE -- requirements
Module: uart_lsu_bridge

---
 rtl/uart_lsu_pkg.sv | 21 ++
 rtl/uart_lsu_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_lsu_bridge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_lsu_pkg.sv
// rtl/uart_lsu_pkg.sv - shared constants and state encoding for the UART load/store bridge
package uart_lsu_pkg;

  // Frame opcodes
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;

  // Single-byte responses
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    MREQ,
    MWAIT,
    RESP
  } state_e;

endpackage

// File: rtl/uart_lsu_bridge.sv
// rtl/uart_lsu_bridge.sv - UART byte-frame to single-word memory load/store bridge
module uart_lsu_bridge #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i
);
  import uart_lsu_pkg::*;

  // Idle counter only needs to reach TIMEOUT_CYC-1
  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e        state_q;
  logic [1:0]    cnt_q;
  logic          is_wr_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [23:0]   resp_q;
  logic [TW-1:0] idle_q;
  logic          rx_ready_q;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [3:0]    mem_be_q;
  logic          busy_q;
  logic          err_q;

  logic          rx_fire;
  logic          tx_fire;
  logic          gnt_fire;
  logic          timeout_d;
  logic          err_set_d;
  logic [31:0]   addr_d;
  logic [31:0]   wdata_d;

  assign rx_fire   = rx_valid_i & rx_ready_q;
  assign tx_fire   = tx_valid_q & tx_ready_i;
  assign gnt_fire  = mem_req_q & mem_gnt_i;
  // Bytes arrive LSB first, so each new byte enters at the top
  assign addr_d    = {rx_data_i, addr_q[31:8]};
  assign wdata_d   = {rx_data_i, wdata_q[31:8]};
  assign timeout_d = ((state_q == ADDR) || (state_q == WDATA)) && !rx_fire &&
                     (idle_q == TW'(TIMEOUT_CYC - 1));

  // Error sources: unknown opcode, misaligned address, inter-byte timeout
  always_comb begin
    err_set_d = 1'b0;
    case (state_q)
      IDLE:  err_set_d = rx_fire && en_i && (rx_data_i != OP_WR) && (rx_data_i != OP_RD);
      ADDR:  err_set_d = timeout_d ||
                         (rx_fire && (cnt_q == 2'd3) && !is_wr_q && (addr_d[1:0] != 2'b00));
      WDATA: err_set_d = timeout_d ||
                         (rx_fire && (cnt_q == 2'd3) && (addr_q[1:0] != 2'b00));
      default: err_set_d = 1'b0;
    endcase
  end

  // Sticky error flag; a new error beats a simultaneous clear
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q <= 1'b0;
    end else if (err_set_d) begin
      err_q <= 1'b1;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end

  // Frame FSM with registered handshake and memory outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      idle_q     <= '0;
      rx_ready_q <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          idle_q <= '0;
          // With en_i low the byte is consumed and dropped
          if (rx_fire && en_i) begin
            busy_q <= 1'b1;
            if ((rx_data_i == OP_WR) || (rx_data_i == OP_RD)) begin
              is_wr_q <= (rx_data_i == OP_WR);
              state_q <= ADDR;
            end else begin
              state_q    <= RESP;
              rx_ready_q <= 1'b0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= RSP_NAK;
            end
          end
        end

        ADDR: begin
          if (rx_fire) begin
            addr_q <= addr_d;
            idle_q <= '0;
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (is_wr_q) begin
                state_q <= WDATA;
              end else if (addr_d[1:0] != 2'b00) begin
                state_q    <= RESP;
                rx_ready_q <= 1'b0;
                tx_valid_q <= 1'b1;
                tx_data_q  <= RSP_NAK;
              end else begin
                state_q    <= MREQ;
                rx_ready_q <= 1'b0;
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_be_q   <= 4'hF;
              end
            end
          end else if (timeout_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end

        WDATA: begin
          if (rx_fire) begin
            wdata_q <= wdata_d;
            idle_q  <= '0;
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              rx_ready_q <= 1'b0;
              // A misaligned write still consumes its data bytes before the NAK
              if (addr_q[1:0] != 2'b00) begin
                state_q    <= RESP;
                tx_valid_q <= 1'b1;
                tx_data_q  <= RSP_NAK;
              end else begin
                state_q   <= MREQ;
                mem_req_q <= 1'b1;
                mem_we_q  <= 1'b1;
                mem_be_q  <= 4'hF;
              end
            end
          end else if (timeout_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end

        MREQ: begin
          if (gnt_fire) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
            if (is_wr_q) begin
              state_q    <= RESP;
              cnt_q      <= '0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= RSP_ACK;
            end else begin
              state_q <= MWAIT;
            end
          end
        end

        MWAIT: begin
          if (mem_rvalid_i) begin
            state_q    <= RESP;
            cnt_q      <= 2'd3;
            tx_valid_q <= 1'b1;
            tx_data_q  <= mem_rdata_i[7:0];
            resp_q     <= mem_rdata_i[31:8];
          end
        end

        RESP: begin
          if (tx_fire) begin
            if (cnt_q == 2'd0) begin
              state_q    <= IDLE;
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              cnt_q     <= cnt_q - 2'd1;
              tx_data_q <= resp_q[7:0];
              resp_q    <= {8'h00, resp_q[23:8]};
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart_lsu_bridge.sv
// tb/tb_uart_lsu_bridge.sv - table-driven scoreboard bench for uart_lsu_bridge
module tb_uart_lsu_bridge;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        en_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        err_o;
  logic        err_clr_i;

  uart_lsu_bridge #(.TIMEOUT_CYC(100)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        en;
    int          nb;
    logic [71:0] rx;
    logic        mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          tx_stall;
    int          ntx;
    logic [31:0] tx;
    logic        err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  vec_t        vecs[8];
  logic [7:0]  exp_tx[$];
  mreq_t       exp_mem[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          req_cycles = 0;
  int          gnt_dly = 0;
  int          tx_stall = 0;
  logic [31:0] rdata_next = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  // Scoreboard: pop expected tx bytes and memory requests as handshakes complete
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (mem_req_o) req_cycles++;
      if (tx_valid_o && tx_ready_i) begin
        if (exp_tx.size() == 0) fail_now($sformatf("tx_unexpected byte %h", tx_data_o));
        else chk("tx_byte", {24'h0, tx_data_o}, {24'h0, exp_tx.pop_front()});
      end
      if (mem_req_o && mem_gnt_i) begin
        if (exp_mem.size() == 0) begin
          fail_now($sformatf("mem_unexpected addr %h", mem_addr_o));
        end else begin
          mreq_t m;
          m = exp_mem.pop_front();
          chk("mem_addr", mem_addr_o, m.addr);
          chk("mem_we", {31'h0, mem_we_o}, {31'h0, m.we});
          chk("mem_be", {28'h0, mem_be_o}, 32'hF);
          if (m.we) chk("mem_wdata", mem_wdata_o, m.wdata);
        end
      end
    end
  end

  // Memory model: grant after gnt_dly cycles, read data two cycles after grant
  initial begin
    int  wcnt = 0;
    int  rvcnt = 0;
    bit  rv_pend = 0;
    bit  gnt_we = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_rvalid_i = 0;
      if (!rstn_i) begin
        mem_gnt_i = 0; wcnt = 0; rv_pend = 0;
      end else if (mem_gnt_i) begin
        mem_gnt_i = 0; wcnt = 0;
        if (!gnt_we) begin rv_pend = 1; rvcnt = 2; end
      end else if (mem_req_o) begin
        if (wcnt >= gnt_dly) begin mem_gnt_i = 1; gnt_we = mem_we_o; end
        else wcnt++;
      end
      if (rv_pend) begin
        if (rvcnt == 0) begin mem_rvalid_i = 1; mem_rdata_i = rdata_next; rv_pend = 0; end
        else rvcnt--;
      end
    end
  end

  // Tx sink: hold ready low for tx_stall cycles before taking each byte
  initial begin
    int scnt = 0;
    tx_ready_i = 0;
    forever begin
      @(posedge clk_i); #1;
      if (tx_ready_i) begin
        tx_ready_i = 0; scnt = 0;
      end else if (tx_valid_o) begin
        if (scnt >= tx_stall) tx_ready_i = 1;
        else scnt++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data_i  = b;
    rx_valid_i = 1;
    @(negedge clk_i);
    while (!rx_ready_o && n < 1000) begin @(negedge clk_i); n++; end
    if (!rx_ready_o) fail_now("rx_ready_timeout");
    @(posedge clk_i); #1;
    rx_valid_i = 0;
  endtask

  task automatic clear_err(input string nm);
    err_clr_i = 1;
    @(posedge clk_i); #1;
    err_clr_i = 0;
    chk(nm, {31'h0, err_o}, 32'h0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx_valid"}, {31'h0, tx_valid_o}, 32'h0);
    chk({tag, "_mem_req"}, {31'h0, mem_req_o}, 32'h0);
    chk({tag, "_mem_we"}, {31'h0, mem_we_o}, 32'h0);
    chk({tag, "_err"}, {31'h0, err_o}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
    chk({tag, "_tx_data"}, {24'h0, tx_data_o}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
    chk({tag, "_mem_be"}, {28'h0, mem_be_o}, 32'h0);
    chk({tag, "_rx_ready"}, {31'h0, rx_ready_o}, 32'h1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n = 0;
    en_i       = v.en;
    gnt_dly    = v.gnt_dly;
    tx_stall   = v.tx_stall;
    rdata_next = v.rdata;
    req_cycles = 0;
    if (v.mem) exp_mem.push_back('{we: v.we, addr: v.addr, wdata: v.wdata});
    for (int i = 0; i < v.ntx; i++) exp_tx.push_back(v.tx[8*i +: 8]);
    for (int i = 0; i < v.nb; i++) send_byte(v.rx[8*i +: 8]);
    en_i = 1;
    @(negedge clk_i);
    while ((busy_o || exp_tx.size() != 0) && n < 3000) begin @(negedge clk_i); n++; end
    if (n >= 3000) fail_now($sformatf("v%0d_done_timeout", idx));
    @(posedge clk_i); #1;
    chk($sformatf("v%0d_tx_left", idx), exp_tx.size(), 32'h0);
    chk($sformatf("v%0d_mem_left", idx), exp_mem.size(), 32'h0);
    if (!v.mem) chk($sformatf("v%0d_no_req", idx), req_cycles, 32'h0);
    chk($sformatf("v%0d_err", idx), {31'h0, err_o}, {31'h0, v.err});
    if (v.err) clear_err($sformatf("v%0d_err_clr", idx));
    exp_tx.delete();
    exp_mem.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //          en  nb  rx frame (byte0 in LSBs)                      mem we  addr          wdata         rdata         gnt stall ntx tx            err
    vecs[0] = '{1'b1, 9, {32'hDEADBEEF, 32'h00001000, 8'h57},       1'b1, 1'b1, 32'h00001000, 32'hDEADBEEF, 32'h0,        0, 0,  1, 32'h06,       1'b0};
    vecs[1] = '{1'b1, 5, {32'h0, 32'h00000004, 8'h52},               1'b1, 1'b0, 32'h00000004, 32'h0,        32'h12345678, 5, 20, 4, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 1, {64'h0, 8'hAA},                             1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        0, 0,  1, 32'h15,       1'b1};
    vecs[3] = '{1'b1, 5, {32'h0, 32'h00000001, 8'h52},               1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        0, 0,  1, 32'h15,       1'b1};
    vecs[4] = '{1'b0, 5, {32'h0, 32'h00001000, 8'h57},               1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        0, 0,  0, 32'h0,        1'b0};
    vecs[5] = '{1'b1, 9, {32'h44332211, 32'h00000002, 8'h57},       1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        0, 0,  1, 32'h15,       1'b1};
    vecs[6] = '{1'b1, 5, {32'h0, 32'hFFFFFFFC, 8'h52},               1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        32'hA5C30F96, 0, 1,  4, 32'hA5C30F96, 1'b0};
    vecs[7] = '{1'b1, 9, {32'h01020304, 32'h80000000, 8'h57},       1'b1, 1'b1, 32'h80000000, 32'h01020304, 32'h0,        2, 3,  1, 32'h06,       1'b0};

    rstn_i = 0; en_i = 1; rx_data_i = '0; rx_valid_i = 0; err_clr_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset("rst");
    rstn_i = 1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Error set and clear in the same cycle: set must win
    en_i = 1;
    req_cycles = 0;
    exp_tx.push_back(8'h15);
    rx_data_i = 8'hAA; rx_valid_i = 1; err_clr_i = 1;
    @(posedge clk_i); #1;
    rx_valid_i = 0; err_clr_i = 0;
    chk("setclr_err", {31'h0, err_o}, 32'h1);
    begin
      int n = 0;
      while ((busy_o || exp_tx.size() != 0) && n < 200) begin @(negedge clk_i); n++; end
      if (n >= 200) fail_now("setclr_done_timeout");
    end
    @(posedge clk_i); #1;
    chk("setclr_no_req", req_cycles, 32'h0);
    clear_err("setclr_err_clr");

    // Inter-byte timeout after opcode and one address byte
    req_cycles = 0;
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (98) @(posedge clk_i);
    #1;
    chk("to_busy_before", {31'h0, busy_o}, 32'h1);
    chk("to_err_before", {31'h0, err_o}, 32'h0);
    repeat (4) @(posedge clk_i);
    #1;
    chk("to_busy_after", {31'h0, busy_o}, 32'h0);
    chk("to_err_after", {31'h0, err_o}, 32'h1);
    chk("to_rx_ready", {31'h0, rx_ready_o}, 32'h1);
    chk("to_no_req", req_cycles, 32'h0);
    clear_err("to_err_clr");
    run_vec(vecs[1], 101);

    // Reset in the middle of the write data phase
    en_i = 1;
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("mid_busy", {31'h0, busy_o}, 32'h1);
    rstn_i = 0;
    #1;
    check_reset("midrst");
    @(posedge clk_i); #1;
    rstn_i = 1;
    @(posedge clk_i); #1;
    run_vec(vecs[7], 107);
    run_vec(vecs[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
